ca_code_correlator: RTL and testbench

Downstream consumer of the C/A code generator. It multiplies incoming baseband I/Q samples by the current code chip (±1) and accumulates over one full 1023-chip code epoch. It then presents the epoch sums to the tracking loop through a valid/ready holding register. It also owns the chip counter that defines the epoch boundaries.

---
 rtl/gps_pkg.sv | 16 +
 rtl/sat_accum.sv | 45 ++++
 rtl/ca_code_correlator.sv | 144 ++++++++++++++
 tb/tb_ca_code_correlator.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/gps_pkg.sv
// Shared GPS receiver definitions: C/A code constants, accumulator word type
// and the correlator output-register states.
package gps_pkg;

  localparam int CA_CODE_LEN = 1023;
  localparam int CA_CHIP_LAT = 2;
  localparam int ACC_W_DEF   = 16;

  typedef logic signed [ACC_W_DEF-1:0] acc_word_t;

  typedef enum logic {
    OUT_EMPTY,
    OUT_FULL
  } out_state_t;

endpackage

// File: rtl/sat_accum.sv
// Signed saturating accumulator with synchronous clear. sum_next exposes the
// running total including the current operand so a dump can capture it.
module sat_accum
  import gps_pkg::*;
#(
  parameter int IN_W  = 5,
  parameter int ACC_W = $bits(acc_word_t)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    en,
  input  logic signed [IN_W-1:0]  din,
  output logic signed [ACC_W-1:0] sum_next
);

  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  logic signed [ACC_W-1:0] acc_reg;
  logic signed [ACC_W:0]   acc_ext;
  logic signed [ACC_W:0]   din_ext;
  logic signed [ACC_W:0]   sum_wide;

  // One guard bit is enough: overflow shows up as disagreement of the top two bits.
  always_comb begin
    acc_ext  = {acc_reg[ACC_W-1], acc_reg};
    din_ext  = (ACC_W+1)'(din);
    sum_wide = acc_ext + din_ext;
    if (!en)
      sum_next = acc_reg;
    else if (sum_wide[ACC_W] != sum_wide[ACC_W-1])
      sum_next = sum_wide[ACC_W] ? ACC_MIN : ACC_MAX;
    else
      sum_next = sum_wide[ACC_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst || clr)
      acc_reg <= '0;
    else
      acc_reg <= sum_next;
  end

endmodule

// File: rtl/ca_code_correlator.sv
// C/A code correlator: wipes the code off I/Q samples, integrates over one
// 1023-chip epoch and hands the sums out through a valid/ready holding register.
module ca_code_correlator
  import gps_pkg::*;
#(
  parameter int SAMPLE_W = 4,
  parameter int ACC_W    = $bits(acc_word_t),
  parameter int CHIP_LAT = CA_CHIP_LAT
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       prn_changed,
  input  logic                       chip_adv,
  input  logic                       chip_in,
  input  logic                       samp_valid,
  input  logic signed [SAMPLE_W-1:0] samp_i,
  input  logic signed [SAMPLE_W-1:0] samp_q,
  output logic                       acc_valid,
  input  logic                       acc_ready,
  output logic signed [ACC_W-1:0]    acc_i,
  output logic signed [ACC_W-1:0]    acc_q,
  output logic [15:0]                acc_cnt,
  output logic                       epoch,
  output logic                       overrun
);

  localparam logic [9:0] CHIP_LAST = 10'(CA_CODE_LEN - 1);

  logic                    clear;
  logic [CHIP_LAT-1:0]     adv_sr_reg;
  logic                    adv_d;
  logic [9:0]              chip_cnt_reg;
  logic                    dump;
  logic signed [SAMPLE_W:0] op_i, op_q;
  logic signed [ACC_W-1:0] sum_i_next, sum_q_next;
  logic [15:0]             cnt_reg, cnt_next;

  out_state_t              state_reg;
  logic                    acc_valid_reg, overrun_reg;
  logic signed [ACC_W-1:0] acc_i_reg, acc_q_reg;
  logic [15:0]             acc_cnt_reg;

  assign clear = rst || prn_changed;

  // Delay chip_adv to line up with the chip actually presented on chip_in.
  generate
    if (CHIP_LAT > 1) begin : g_dl_multi
      always_ff @(posedge clk) begin
        if (clear) adv_sr_reg <= '0;
        else       adv_sr_reg <= {adv_sr_reg[CHIP_LAT-2:0], chip_adv};
      end
    end else begin : g_dl_single
      always_ff @(posedge clk) begin
        if (clear) adv_sr_reg <= '0;
        else       adv_sr_reg <= chip_adv;
      end
    end
  endgenerate

  assign adv_d = adv_sr_reg[CHIP_LAT-1];

  always_ff @(posedge clk) begin
    if (clear)
      chip_cnt_reg <= '0;
    else if (adv_d)
      chip_cnt_reg <= (chip_cnt_reg == CHIP_LAST) ? 10'd0 : chip_cnt_reg + 10'd1;
  end

  assign dump  = adv_d && (chip_cnt_reg == CHIP_LAST) && !clear;
  assign epoch = dump;

  // Widened before negation so the most negative sample maps to a positive value.
  always_comb begin
    op_i = (SAMPLE_W+1)'(samp_i);
    op_q = (SAMPLE_W+1)'(samp_q);
    if (chip_in) begin
      op_i = -op_i;
      op_q = -op_q;
    end
  end

  sat_accum #(.IN_W(SAMPLE_W+1), .ACC_W(ACC_W)) u_acc_i (
    .clk(clk), .rst(rst), .clr(prn_changed || dump), .en(samp_valid),
    .din(op_i), .sum_next(sum_i_next)
  );

  sat_accum #(.IN_W(SAMPLE_W+1), .ACC_W(ACC_W)) u_acc_q (
    .clk(clk), .rst(rst), .clr(prn_changed || dump), .en(samp_valid),
    .din(op_q), .sum_next(sum_q_next)
  );

  assign cnt_next = (samp_valid && cnt_reg != 16'hFFFF) ? cnt_reg + 16'd1 : cnt_reg;

  always_ff @(posedge clk) begin
    if (clear || dump) cnt_reg <= '0;
    else               cnt_reg <= cnt_next;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      state_reg     <= OUT_EMPTY;
      acc_valid_reg <= 1'b0;
      acc_i_reg     <= '0;
      acc_q_reg     <= '0;
      acc_cnt_reg   <= '0;
      overrun_reg   <= 1'b0;
    end else begin
      case (state_reg)
        OUT_EMPTY: begin
          if (dump) begin
            state_reg     <= OUT_FULL;
            acc_valid_reg <= 1'b1;
            acc_i_reg     <= sum_i_next;
            acc_q_reg     <= sum_q_next;
            acc_cnt_reg   <= cnt_next;
          end
        end
        OUT_FULL: begin
          if (acc_ready && dump) begin
            acc_i_reg   <= sum_i_next;
            acc_q_reg   <= sum_q_next;
            acc_cnt_reg <= cnt_next;
          end else if (acc_ready) begin
            state_reg     <= OUT_EMPTY;
            acc_valid_reg <= 1'b0;
          end else if (dump) begin
            overrun_reg <= 1'b1;
          end
        end
        default: begin
          state_reg     <= OUT_EMPTY;
          acc_valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign acc_valid = acc_valid_reg;
  assign acc_i     = acc_i_reg;
  assign acc_q     = acc_q_reg;
  assign acc_cnt   = acc_cnt_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_ca_code_correlator.sv
// Directed bench for ca_code_correlator: epoch vector table plus backpressure,
// restart and reset sequences.
module tb_ca_code_correlator;
  import gps_pkg::*;

  logic              clk;
  logic              rst;
  logic              prn_changed;
  logic              chip_adv;
  logic              chip_in;
  logic              samp_valid;
  logic signed [3:0] samp_i;
  logic signed [3:0] samp_q;
  logic              acc_valid;
  logic              acc_ready;
  acc_word_t         acc_i;
  acc_word_t         acc_q;
  logic [15:0]       acc_cnt;
  logic              epoch;
  logic              overrun;

  int total;
  int bad;
  int gk;     // index of the cycle whose inputs are being driven
  int cur_p;  // chip_adv period in cycles

  typedef struct {
    logic chip;
    int   si;
    int   sq;
    int   p;
    int   exp_i;
    int   exp_q;
    int   exp_cnt;
  } vec_t;

  vec_t vecs[6];

  ca_code_correlator #(.SAMPLE_W(4), .ACC_W(16), .CHIP_LAT(2)) dut (
    .clk(clk), .rst(rst), .prn_changed(prn_changed), .chip_adv(chip_adv),
    .chip_in(chip_in), .samp_valid(samp_valid), .samp_i(samp_i), .samp_q(samp_q),
    .acc_valid(acc_valid), .acc_ready(acc_ready), .acc_i(acc_i), .acc_q(acc_q),
    .acc_cnt(acc_cnt), .epoch(epoch), .overrun(overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Pulses land at gk % p == p-3, so every epoch spans exactly 1023*p samples.
  task automatic drive();
    rst         = 1'b0;
    prn_changed = 1'b0;
    chip_adv    = (gk % cur_p == cur_p - 3);
    samp_valid  = 1'b1;
    gk++;
  endtask

  task automatic do_restart();
    @(negedge clk);
    rst         = 1'b0;
    prn_changed = 1'b1;
    chip_adv    = 1'b1;
    samp_valid  = 1'b1;
    gk          = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst         = 1'b1;
    prn_changed = 1'b0;
    chip_adv    = 1'b1;
    samp_valid  = 1'b1;
    gk          = 0;
  endtask

  // Runs until the next epoch pulse (bounded); rdy_dump is driven in the dump cycle.
  task automatic run_epoch(input int p, input logic rdy_dump, output int k_seen);
    k_seen = -1;
    cur_p  = p;
    for (int n = 0; n < p * 1023 + 20; n++) begin
      @(negedge clk);
      if (epoch) begin
        k_seen    = gk;
        acc_ready = rdy_dump;
        drive();
        break;
      end
      drive();
    end
  endtask

  initial begin
    int k;
    total       = 0;
    bad         = 0;
    gk          = 0;
    cur_p       = 4;
    rst         = 1'b1;
    prn_changed = 1'b0;
    chip_adv    = 1'b0;
    chip_in     = 1'b0;
    samp_valid  = 1'b0;
    samp_i      = '0;
    samp_q      = '0;
    acc_ready   = 1'b1;

    vecs[0] = '{1'b0,  1, -1, 4,   4092,  -4092, 4092};
    vecs[1] = '{1'b1,  1, -1, 4,  -4092,   4092, 4092};
    vecs[2] = '{1'b0,  7, -8, 8,  32767, -32768, 8184};
    vecs[3] = '{1'b0, -8,  7, 8, -32768,  32767, 8184};
    vecs[4] = '{1'b1, -8,  7, 8,  32767, -32768, 8184};
    vecs[5] = '{1'b1,  3, -2, 4, -12276,   8184, 4092};

    repeat (3) @(negedge clk);
    chk("reset acc_valid", int'(acc_valid), 0);
    chk("reset acc_i", int'(acc_i), 0);
    chk("reset acc_q", int'(acc_q), 0);
    chk("reset acc_cnt", int'(acc_cnt), 0);
    chk("reset epoch", int'(epoch), 0);
    chk("reset overrun", int'(overrun), 0);

    foreach (vecs[v]) begin
      acc_ready = 1'b1;
      chip_in   = vecs[v].chip;
      samp_i    = 4'(vecs[v].si);
      samp_q    = 4'(vecs[v].sq);
      do_restart();
      run_epoch(vecs[v].p, 1'b1, k);
      chk($sformatf("vec%0d epoch cycle", v), k, vecs[v].p * 1023 - 1);
      @(negedge clk);
      chk($sformatf("vec%0d acc_valid", v), int'(acc_valid), 1);
      chk($sformatf("vec%0d acc_i", v), int'(acc_i), vecs[v].exp_i);
      chk($sformatf("vec%0d acc_q", v), int'(acc_q), vecs[v].exp_q);
      chk($sformatf("vec%0d acc_cnt", v), int'(acc_cnt), vecs[v].exp_cnt);
      drive();
    end

    // Backpressure: two epochs with acc_ready low, then ready rises on the third dump.
    chip_in   = 1'b0;
    samp_i    = 4'sd1;
    samp_q    = -4'sd1;
    acc_ready = 1'b0;
    do_restart();
    run_epoch(4, 1'b0, k);
    chk("bp first epoch cycle", k, 4091);
    @(negedge clk);
    chk("bp first acc_valid", int'(acc_valid), 1);
    chk("bp first acc_i", int'(acc_i), 4092);
    chk("bp first overrun", int'(overrun), 0);
    drive();
    samp_i = 4'sd2;
    run_epoch(4, 1'b0, k);
    chk("bp second epoch cycle", k, 2 * 4092 - 1);
    @(negedge clk);
    chk("bp held acc_i", int'(acc_i), 4092);
    chk("bp held acc_q", int'(acc_q), -4092);
    chk("bp held acc_valid", int'(acc_valid), 1);
    chk("bp overrun set", int'(overrun), 1);
    drive();
    samp_i = 4'sd3;
    run_epoch(4, 1'b1, k);
    chk("bp third epoch cycle", k, 3 * 4092 - 1);
    @(negedge clk);
    chk("bp third acc_valid", int'(acc_valid), 1);
    chk("bp third acc_i", int'(acc_i), 12276);
    chk("bp third acc_cnt", int'(acc_cnt), 4092);
    chk("bp third overrun", int'(overrun), 1);
    drive();
    @(negedge clk);
    chk("bp drained acc_valid", int'(acc_valid), 0);
    acc_ready = 1'b0;
    drive();

    // Restart mid-epoch while a result is pending and overrun is set.
    samp_i = 4'sd1;
    run_epoch(4, 1'b0, k);
    @(negedge clk);
    chk("rs pending acc_valid", int'(acc_valid), 1);
    drive();
    repeat (500 * 4) begin
      @(negedge clk);
      drive();
    end
    chk("rs overrun before", int'(overrun), 1);
    do_restart();
    @(negedge clk);
    chk("rs acc_valid", int'(acc_valid), 0);
    chk("rs overrun", int'(overrun), 0);
    drive();
    run_epoch(4, 1'b0, k);
    chk("rs epoch cycle", k, 4091);
    @(negedge clk);
    chk("rs acc_cnt", int'(acc_cnt), 4092);
    chk("rs acc_i", int'(acc_i), 4092);
    drive();

    // Reset mid-epoch with acc_valid high; the next epoch must be a full one.
    repeat (100) begin
      @(negedge clk);
      drive();
    end
    chk("rst pre acc_valid", int'(acc_valid), 1);
    do_reset();
    @(negedge clk);
    chk("rst acc_valid", int'(acc_valid), 0);
    chk("rst acc_i", int'(acc_i), 0);
    chk("rst acc_q", int'(acc_q), 0);
    chk("rst acc_cnt", int'(acc_cnt), 0);
    chk("rst epoch", int'(epoch), 0);
    chk("rst overrun", int'(overrun), 0);
    drive();
    run_epoch(4, 1'b1, k);
    chk("rst next epoch cycle", k, 4091);
    @(negedge clk);
    chk("rst next acc_cnt", int'(acc_cnt), 4092);
    drive();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
